// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run_ctrl start/halt sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    DONE
  } run_state_t;

  localparam int unsigned RUN_CTRL_INIT_MIN_DEF = 2;

  // A zero minimum still needs one INIT cycle to pulse core_rst.
  function automatic int unsigned init_min_eff(input int unsigned m);
    return (m == 0) ? 1 : m;
  endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/run_ctrl.sv
// Host start/halt sequencer: core reset pulse, run window, cycle count and watchdog.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned     CNT_W          = 32,
  parameter longint unsigned TIMEOUT_CYCLES = 64'd1_000_000,
  parameter int unsigned     INIT_MIN       = RUN_CTRL_INIT_MIN_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             core_rst,
  output logic             run_en,
  output logic             Halt,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned     INIT_MIN_EFF = init_min_eff(INIT_MIN);
  localparam int unsigned     INIT_W       = $clog2(INIT_MIN_EFF + 1);
  localparam longint unsigned CNT_MAX      = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                           : ((64'd1 << CNT_W) - 64'd1);
  // The count can never reach a limit beyond its own range, so such a watchdog is off.
  localparam bit              WD_EN        = (TIMEOUT_CYCLES != 64'd0) &&
                                             (TIMEOUT_CYCLES <= CNT_MAX);
  localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 64'd1);

  if ((TIMEOUT_CYCLES != 64'd0) && !WD_EN) begin : g_wd_warn
    $warning("run_ctrl: TIMEOUT_CYCLES does not fit in CNT_W bits, watchdog disabled");
  end

  run_state_t        state_q;
  run_state_t        state_d;
  logic [INIT_W-1:0] init_cnt_q;
  logic [INIT_W-1:0] init_cnt_d;
  logic              timeout_q;
  logic              timeout_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              wd_hit;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    timeout_d  = timeout_q;
    wd_hit     = WD_EN && (cycle_count == WD_LAST);

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        timeout_d = 1'b0;
        if (!start && (init_cnt_q >= INIT_W'(INIT_MIN_EFF))) state_d = RUN;
      end
      RUN: begin
        if (start) begin
          state_d = INIT;
        end else if (halt_req) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (wd_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (start) state_d = INIT;
      end
      default: state_d = IDLE;
    endcase

    // The entry cycle counts as the first INIT cycle, so INIT lasts exactly INIT_MIN cycles.
    if (state_d == INIT) begin
      timeout_d  = 1'b0;
      init_cnt_d = (state_q != INIT)                      ? INIT_W'(1) :
                   (init_cnt_q >= INIT_W'(INIT_MIN_EFF)) ? init_cnt_q :
                                                           init_cnt_q + INIT_W'(1);
    end

    cnt_clr  = (state_q == INIT) || (state_d == INIT);
    cnt_en   = (state_q == RUN);

    core_rst = (state_q == IDLE) || (state_q == INIT);
    run_en   = (state_q == RUN);
    Halt     = (state_q == DONE);
    timeout  = timeout_q;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      init_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk (CLK),
    .rst (Reset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (cycle_count)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: one watchdog/INIT_MIN=4 instance, one narrow saturating instance.
module tb_run_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start, halt_req, start2, halt2;
  logic        core_rst, run_en, Halt, timeout;
  logic [31:0] cycle_count;
  logic        core_rst2, run_en2, Halt2, timeout2;
  logic [3:0]  cycle_count2;

  int checks   = 0;
  int failures = 0;
  int n;
  int runs;
  logic bad;

  always #5 CLK = ~CLK;

  run_ctrl #(
    .CNT_W          (32),
    .TIMEOUT_CYCLES (64'd50),
    .INIT_MIN       (4)
  ) u_dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .start       (start),
    .halt_req    (halt_req),
    .core_rst    (core_rst),
    .run_en      (run_en),
    .Halt        (Halt),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  run_ctrl #(
    .CNT_W          (4),
    .TIMEOUT_CYCLES (64'd0),
    .INIT_MIN       (0)
  ) u_sat (
    .CLK         (CLK),
    .Reset       (Reset),
    .start       (start2),
    .halt_req    (halt2),
    .core_rst    (core_rst2),
    .run_en      (run_en2),
    .Halt        (Halt2),
    .timeout     (timeout2),
    .cycle_count (cycle_count2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_run(input string tag);
    int k;
    k = 0;
    while (!run_en && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check(tag, run_en, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_time_limit: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; start = 1'b0; halt_req = 1'b0; start2 = 1'b0; halt2 = 1'b0;
    @(negedge CLK);
    check("rst_core_rst", core_rst, 1);
    check("rst_run_en", run_en, 0);
    check("rst_halt", Halt, 0);
    check("rst_timeout", timeout, 0);
    check("rst_count", cycle_count, 0);
    Reset = 1'b0;

    // Test 1: start held 10 clk, halt 20 clk after run_en rises
    start = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (!core_rst || run_en) bad = 1'b1;
    end
    check("init_held", bad, 0);
    start = 1'b0;
    @(negedge CLK);
    check("run_latency", run_en, 1);
    runs = 1;
    repeat (20) begin
      @(negedge CLK);
      if (run_en) runs++;
    end
    halt_req = 1'b1;
    @(negedge CLK);
    halt_req = 1'b0;
    check("run_len", runs, 21);
    check("halt_set", Halt, 1);
    check("halt_run_en", run_en, 0);
    check("halt_core_rst", core_rst, 0);
    check("halt_timeout", timeout, 0);
    check("halt_count", cycle_count, 21);

    // halt_req in DONE is ignored, count holds
    halt_req = 1'b1;
    @(negedge CLK);
    halt_req = 1'b0;
    @(negedge CLK);
    check("done_hold_cnt", cycle_count, 21);
    check("done_hold_halt", Halt, 1);

    // DONE + start: Halt falls, count clears
    start = 1'b1;
    @(negedge CLK);
    check("restart_halt", Halt, 0);
    check("restart_core_rst", core_rst, 1);
    check("restart_count", cycle_count, 0);
    @(negedge CLK);
    start = 1'b0;
    wait_run("run_t4");

    // Test 4: abort at RUN cycle 7
    repeat (6) @(negedge CLK);
    check("pre_abort_count", cycle_count, 6);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("abort_core_rst", core_rst, 1);
    check("abort_run_en", run_en, 0);
    check("abort_halt", Halt, 0);
    check("abort_count", cycle_count, 0);
    wait_run("run_t4b");

    // Test 2: watchdog fires after exactly 50 RUN cycles
    n = 0;
    while (run_en && n < 200) begin
      n++;
      if (n == 6) check("recount", cycle_count, 5);
      @(negedge CLK);
    end
    check("wd_len", n, 50);
    check("wd_halt", Halt, 1);
    check("wd_timeout", timeout, 1);
    check("wd_count", cycle_count, 50);

    // Test 3: halt and watchdog in the same cycle
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_run("run_t3");
    check("t3_timeout_clr", timeout, 0);
    repeat (49) @(negedge CLK);
    halt_req = 1'b1;
    @(negedge CLK);
    halt_req = 1'b0;
    check("tie_halt", Halt, 1);
    check("tie_timeout", timeout, 0);
    check("tie_count", cycle_count, 50);
    check("tie_run_en", run_en, 0);

    // Test 5: 1-clk start pulse, INIT_MIN=4
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (core_rst && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check("init_min4", n, 4);
    check("init_min4_run", run_en, 1);

    // Test 6: async reset mid-RUN
    repeat (3) @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    check("arst_run_core_rst", core_rst, 1);
    check("arst_run_run_en", run_en, 0);
    check("arst_run_count", cycle_count, 0);
    @(negedge CLK);
    Reset = 1'b0;

    // async reset mid-DONE after a watchdog stop
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_run("run_t6");
    n = 0;
    while (run_en && n < 200) begin
      n++;
      @(negedge CLK);
    end
    check("pre_arst_timeout", timeout, 1);
    #2 Reset = 1'b1;
    #1;
    check("arst_done_halt", Halt, 0);
    check("arst_done_timeout", timeout, 0);
    check("arst_done_count", cycle_count, 0);
    check("arst_done_core_rst", core_rst, 1);
    @(negedge CLK);
    Reset = 1'b0;

    // Narrow instance: halt_req in IDLE ignored, INIT_MIN=0 -> 1, saturation, no watchdog
    halt2 = 1'b1;
    @(negedge CLK);
    halt2 = 1'b0;
    check("idle_halt_ign", Halt2, 0);
    check("idle_core_rst", core_rst2, 1);
    start2 = 1'b1;
    @(negedge CLK);
    start2 = 1'b0;
    n = 0;
    while (core_rst2 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check("init_min0", n, 1);
    repeat (20) @(negedge CLK);
    check("sat_count", cycle_count2, 15);
    check("sat_run_en", run_en2, 1);
    check("sat_no_wd", Halt2, 0);
    halt2 = 1'b1;
    @(negedge CLK);
    halt2 = 1'b0;
    check("sat_halt", Halt2, 1);
    check("sat_timeout", timeout2, 0);
    check("sat_halt_count", cycle_count2, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
